// File: rtl/vc_controller.sv
// Control FSM for the 8-way fully-associative victim cache: services L1 fills and evictions,
// sequences writebacks to memory and keeps saturating hit/miss/writeback counters.
module vc_controller #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 l1_read,
  input  logic                 l1_write,
  input  logic                 l1_dirty,
  output logic                 l1_resp,
  output logic                 l1_rdata_sel,
  input  logic                 VC_hit,
  input  logic                 VC_hit_dirty,
  input  logic [2:0]           way,
  input  logic [2:0]           lru_way,
  input  logic                 VC_LRU_dirty,
  output logic [2:0]           data_index,
  output logic                 load_VC,
  output logic                 load_VC_dirty,
  output logic                 VC_dirty_bit,
  output logic                 load_LRU,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_sel,
  input  logic                 mem_resp,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] wb_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StRdHit,
    StRdMem,
    StWrCheck,
    StWb,
    StInstall,
    StResp
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [2:0]             victim_q, victim_d;
  logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0]   wb_cnt_q, wb_cnt_d;
  logic                   hit_inc, miss_inc, wb_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      victim_q   <= 3'd0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    wb_inc        = 1'b0;
    l1_resp       = 1'b0;
    l1_rdata_sel  = 1'b0;
    data_index    = 3'd0;
    load_VC       = 1'b0;
    load_VC_dirty = 1'b0;
    VC_dirty_bit  = 1'b0;
    load_LRU      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_sel       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Evictions win over fills; a held read is picked up after RESP.
        if (l1_write) begin
          state_d = StWrCheck;
        end else if (l1_read) begin
          if (VC_hit) begin
            state_d = StRdHit;
          end else begin
            state_d  = StRdMem;
            miss_inc = 1'b1;
          end
        end
      end
      StRdHit: begin
        data_index = way;
        l1_resp    = 1'b1;
        load_LRU   = 1'b1;
        hit_inc    = 1'b1;
        state_d    = StResp;
      end
      StRdMem: begin
        mem_read     = 1'b1;
        l1_rdata_sel = 1'b1;
        if (mem_resp) begin
          l1_resp = 1'b1;
          state_d = StResp;
        end
      end
      StWrCheck: begin
        if (VC_hit) begin
          data_index    = way;
          load_VC       = 1'b1;
          load_VC_dirty = 1'b1;
          load_LRU      = 1'b1;
          l1_resp       = 1'b1;
          VC_dirty_bit  = VC_hit_dirty | l1_dirty;
          state_d       = StResp;
        end else begin
          data_index = lru_way;
          victim_d   = lru_way;
          state_d    = VC_LRU_dirty ? StWb : StInstall;
        end
      end
      StWb: begin
        // Victim index is held so LRU updates cannot redirect the writeback.
        data_index = victim_q;
        mem_write  = 1'b1;
        mem_sel    = 1'b1;
        if (mem_resp) begin
          wb_inc  = 1'b1;
          state_d = StInstall;
        end
      end
      StInstall: begin
        data_index    = victim_q;
        load_VC       = 1'b1;
        load_VC_dirty = 1'b1;
        VC_dirty_bit  = l1_dirty;
        load_LRU      = 1'b1;
        l1_resp       = 1'b1;
        state_d       = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    hit_cnt_d  = (hit_inc && hit_cnt_q != CntMax) ? hit_cnt_q + CntOne : hit_cnt_q;
    miss_cnt_d = (miss_inc && miss_cnt_q != CntMax) ? miss_cnt_q + CntOne : miss_cnt_q;
    wb_cnt_d   = (wb_inc && wb_cnt_q != CntMax) ? wb_cnt_q + CntOne : wb_cnt_q;
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;

endmodule

// File: tb/tb_vc_controller.sv
// Directed bench for vc_controller; narrow counters make saturation reachable.
module tb_vc_controller;

  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         l1_read = 1'b0, l1_write = 1'b0, l1_dirty = 1'b0;
  logic         l1_resp, l1_rdata_sel;
  logic         VC_hit = 1'b0, VC_hit_dirty = 1'b0;
  logic [2:0]   way = 3'd0, lru_way = 3'd0;
  logic         VC_LRU_dirty = 1'b0;
  logic [2:0]   data_index;
  logic         load_VC, load_VC_dirty, VC_dirty_bit, load_LRU;
  logic         mem_read, mem_write, mem_sel;
  logic         mem_resp = 1'b0;
  logic [W-1:0] hit_cnt, miss_cnt, wb_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int resp_pulses = 0;
  int mem_rd_cycles = 0;

  vc_controller #(.CNT_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .l1_read      (l1_read),
    .l1_write     (l1_write),
    .l1_dirty     (l1_dirty),
    .l1_resp      (l1_resp),
    .l1_rdata_sel (l1_rdata_sel),
    .VC_hit       (VC_hit),
    .VC_hit_dirty (VC_hit_dirty),
    .way          (way),
    .lru_way      (lru_way),
    .VC_LRU_dirty (VC_LRU_dirty),
    .data_index   (data_index),
    .load_VC      (load_VC),
    .load_VC_dirty(load_VC_dirty),
    .VC_dirty_bit (VC_dirty_bit),
    .load_LRU     (load_LRU),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_sel      (mem_sel),
    .mem_resp     (mem_resp),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .wb_cnt       (wb_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (l1_resp) resp_pulses++;
    if (mem_read) mem_rd_cycles++;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if ({l1_resp, l1_rdata_sel, load_VC, load_VC_dirty, VC_dirty_bit, load_LRU,
         mem_read, mem_write, mem_sel, data_index} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0", {l1_resp, l1_rdata_sel, load_VC,
               load_VC_dirty, VC_dirty_bit, load_LRU, mem_read, mem_write, mem_sel, data_index});
    end
    n_cmp++;
    if ({hit_cnt, miss_cnt, wb_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", hit_cnt, miss_cnt, wb_cnt);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_read_miss();
    int rd0, rs0;
    rd0 = mem_rd_cycles;
    rs0 = resp_pulses;
    l1_read = 1'b1;
    VC_hit  = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      mem_resp = (i == 4);
      @(negedge clk);
      n_cmp++;
      if ({mem_read, mem_sel, l1_rdata_sel, load_VC} !== 4'b1010) begin
        n_bad++;
        $display("FAIL rdmiss_ctrl[%0d]: got %b want 1010", i,
                 {mem_read, mem_sel, l1_rdata_sel, load_VC});
      end
      n_cmp++;
      if (l1_resp !== (i == 4)) begin
        n_bad++;
        $display("FAIL rdmiss_resp[%0d]: got %b want %b", i, l1_resp, (i == 4));
      end
      step();
    end
    mem_resp = 1'b0;
    l1_read  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ((mem_rd_cycles - rd0) !== 4) begin
      n_bad++;
      $display("FAIL rdmiss_rd_cycles: got %0d want 4", mem_rd_cycles - rd0);
    end
    n_cmp++;
    if ({miss_cnt, hit_cnt} !== {2'd1, 2'd0} || (resp_pulses - rs0) !== 1) begin
      n_bad++;
      $display("FAIL rdmiss_cnt: got miss=%0d hit=%0d pulses=%0d want 1 0 1",
               miss_cnt, hit_cnt, resp_pulses - rs0);
    end
    step();
  endtask

  task automatic test_read_hit();
    l1_read = 1'b1;
    VC_hit  = 1'b1;
    way     = 3'd5;
    step();
    @(negedge clk);
    n_cmp++;
    if ({data_index, l1_resp, load_LRU, l1_rdata_sel, load_VC, mem_read} !== 8'b101_11000) begin
      n_bad++;
      $display("FAIL rdhit_ctrl: got %b want 10111000",
               {data_index, l1_resp, load_LRU, l1_rdata_sel, load_VC, mem_read});
    end
    step();
    l1_read = 1'b0;
    VC_hit  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({hit_cnt, miss_cnt, l1_resp} !== {2'd1, 2'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL rdhit_cnt: got hit=%0d miss=%0d resp=%b want 1 1 0",
               hit_cnt, miss_cnt, l1_resp);
    end
    step();
  endtask

  task automatic test_write_hit();
    l1_write     = 1'b1;
    l1_dirty     = 1'b0;
    VC_hit       = 1'b1;
    way          = 3'd2;
    VC_hit_dirty = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({data_index, load_VC, load_VC_dirty, VC_dirty_bit, load_LRU, l1_resp, mem_read,
         mem_write} !== 10'b010_1111100) begin
      n_bad++;
      $display("FAIL wrhit_ctrl: got %b want 0101111100", {data_index, load_VC, load_VC_dirty,
               VC_dirty_bit, load_LRU, l1_resp, mem_read, mem_write});
    end
    step();
    l1_write     = 1'b0;
    VC_hit       = 1'b0;
    VC_hit_dirty = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({l1_resp, load_VC, mem_write} !== 3'b000) begin
      n_bad++;
      $display("FAIL wrhit_resp_state: got %b want 000", {l1_resp, load_VC, mem_write});
    end
    step();
  endtask

  task automatic test_write_wb();
    l1_write     = 1'b1;
    l1_dirty     = 1'b1;
    VC_hit       = 1'b0;
    lru_way      = 3'd7;
    VC_LRU_dirty = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({data_index, l1_resp, mem_write, load_VC} !== 6'b111_000) begin
      n_bad++;
      $display("FAIL wb_check: got %b want 111000", {data_index, l1_resp, mem_write, load_VC});
    end
    step();
    lru_way      = 3'd3;
    VC_LRU_dirty = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      mem_resp = (i == 3);
      @(negedge clk);
      n_cmp++;
      if ({mem_write, mem_sel, mem_read, data_index, load_VC, l1_resp} !== 8'b110_111_00) begin
        n_bad++;
        $display("FAIL wb_ctrl[%0d]: got %b want 11011100", i,
                 {mem_write, mem_sel, mem_read, data_index, load_VC, l1_resp});
      end
      step();
    end
    mem_resp = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({data_index, load_VC, load_VC_dirty, VC_dirty_bit, load_LRU, l1_resp, mem_write}
        !== 9'b111_111110) begin
      n_bad++;
      $display("FAIL wb_install: got %b want 111111110", {data_index, load_VC, load_VC_dirty,
               VC_dirty_bit, load_LRU, l1_resp, mem_write});
    end
    n_cmp++;
    if (wb_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL wb_cnt: got %0d want 1", wb_cnt);
    end
    step();
    l1_write = 1'b0;
    l1_dirty = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int rs0;
    rs0          = resp_pulses;
    l1_read      = 1'b1;
    l1_write     = 1'b1;
    l1_dirty     = 1'b0;
    VC_hit       = 1'b0;
    lru_way      = 3'd1;
    VC_LRU_dirty = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if ({data_index, l1_resp, mem_write, mem_read} !== 6'b001_000) begin
      n_bad++;
      $display("FAIL b2b_check: got %b want 001000", {data_index, l1_resp, mem_write, mem_read});
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({data_index, load_VC, VC_dirty_bit, l1_resp} !== 6'b001_101) begin
      n_bad++;
      $display("FAIL b2b_install: got %b want 001101", {data_index, load_VC, VC_dirty_bit,
               l1_resp});
    end
    step();
    l1_write = 1'b0;
    VC_hit   = 1'b1;
    way      = 3'd4;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if ({data_index, l1_resp, l1_rdata_sel, hit_cnt} !== {3'd4, 1'b1, 1'b0, 2'd1}) begin
      n_bad++;
      $display("FAIL b2b_read: got idx=%0d resp=%b sel=%b hit=%0d want 4 1 0 1",
               data_index, l1_resp, l1_rdata_sel, hit_cnt);
    end
    step();
    l1_read = 1'b0;
    VC_hit  = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if ((resp_pulses - rs0) !== 2 || hit_cnt !== 2'd2) begin
      n_bad++;
      $display("FAIL b2b_pulses: got %0d hit=%0d want 2 2", resp_pulses - rs0, hit_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid_wb();
    int rs0;
    rs0          = resp_pulses;
    l1_write     = 1'b1;
    VC_hit       = 1'b0;
    lru_way      = 3'd6;
    VC_LRU_dirty = 1'b1;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if ({mem_write, mem_sel, data_index} !== 5'b11_110) begin
      n_bad++;
      $display("FAIL rstwb_inwb: got %b want 11110", {mem_write, mem_sel, data_index});
    end
    step();
    reset    = 1'b1;
    l1_write = 1'b0;
    step();
    reset    = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_write, mem_read, l1_resp, data_index} !== 6'd0 ||
        {hit_cnt, miss_cnt, wb_cnt} !== '0) begin
      n_bad++;
      $display("FAIL rstwb_abort: got wr=%b rd=%b resp=%b idx=%0d cnt=%0d/%0d/%0d want zeros",
               mem_write, mem_read, l1_resp, data_index, hit_cnt, miss_cnt, wb_cnt);
    end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_write, mem_read, l1_resp, load_VC, wb_cnt} !== '0 || (resp_pulses - rs0) !== 0) begin
      n_bad++;
      $display("FAIL rstwb_late_resp: got wr=%b rd=%b resp=%b ld=%b wb=%0d pulses=%0d want 0",
               mem_write, mem_read, l1_resp, load_VC, wb_cnt, resp_pulses - rs0);
    end
    step();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      l1_read = 1'b1;
      VC_hit  = 1'b1;
      way     = 3'd0;
      step();
      step();
      l1_read = 1'b0;
      VC_hit  = 1'b0;
      step();
    end
    @(negedge clk);
    n_cmp++;
    if (hit_cnt !== 2'd3) begin
      n_bad++;
      $display("FAIL sat_hit_cnt: got %0d want 3", hit_cnt);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_wb();
    test_back_to_back();
    test_reset_mid_wb();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
